// File: rtl/subtractor_nbits_serial.sv
// subtractor_nbits_serial: chunk-serial A - B - Bin with borrow-out and valid/ready handshakes
module subtractor_nbits_serial #(
    parameter int WIDTH = 15,
    parameter int CHUNK = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Bin,
    input  logic             i_Valid,
    output logic             o_Ready,
    output logic [WIDTH-1:0] o_Diff,
    output logic             o_Bout,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic             o_Busy
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = PW > 1 ? $clog2(PW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   a_q, b_q, diff_q;
    logic            borrow_q, bout_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   base;
    logic [CHUNK:0]  res;
    logic            last;

    assign o_Diff = diff_q[WIDTH-1:0];
    assign o_Bout = bout_q;

    // State register; reset aborts any operation in flight
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Operands are zero-padded to whole chunks, so the borrow out of the padded top equals the borrow at bit WIDTH
    always_comb begin
        base      = IW'(32'(cnt_q) * CHUNK);
        last      = cnt_q == CW'(NCHUNK - 1);
        res       = {1'b0, a_q[base +: CHUNK]} - {1'b0, b_q[base +: CHUNK]} - {{CHUNK{1'b0}}, borrow_q};
        state_nxt = (state == IDLE && i_Valid) ? RUN  :
                    (state == RUN  && last)    ? DONE :
                    (state == DONE && i_Ready) ? IDLE : state;
        o_Ready   = state == IDLE;
        o_Busy    = state != IDLE;
        o_Valid   = state == DONE;
    end

    // Latch operands on accept, then fold one chunk per cycle into the result and borrow chain
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (state == IDLE && i_Valid) begin
            a_q      <= PW'(i_A);
            b_q      <= PW'(i_B);
            borrow_q <= i_Bin;
            cnt_q    <= '0;
        end else if (state == RUN) begin
            diff_q[base +: CHUNK] <= res[CHUNK-1:0];
            borrow_q              <= res[CHUNK];
            cnt_q                 <= cnt_q + CW'(1);
            if (last) bout_q <= res[CHUNK];
        end
    end
endmodule

// File: tb/tb_subtractor_nbits_serial.sv
// tb_subtractor_nbits_serial: directed and swept checks of the serial subtractor at CHUNK=4, 1 and 15
module tb_subtractor_nbits_serial;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [14:0] a = '0, b = '0;
    logic        bin = 1'b0, vin = 1'b0, rin = 1'b0;
    logic        r4, v4, y4, bo4, r1, v1, y1, bo1, r15, v15, y15, bo15;
    logic [14:0] d4, d1, d15;
    int          tests = 0, fails = 0;

    logic [14:0] ba  [5] = '{15'h1234, 15'h0000, 15'h4321, 15'h7FFF, 15'h0000};
    logic [14:0] bb  [5] = '{15'h1234, 15'h7FFF, 15'h4321, 15'h0000, 15'h0000};
    logic        bbi [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    subtractor_nbits_serial #(.WIDTH(15), .CHUNK(4)) u4 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_A(a), .i_B(b), .i_Bin(bin), .i_Valid(vin), .o_Ready(r4),
        .o_Diff(d4), .o_Bout(bo4), .o_Valid(v4), .i_Ready(rin), .o_Busy(y4));
    subtractor_nbits_serial #(.WIDTH(15), .CHUNK(1)) u1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_A(a), .i_B(b), .i_Bin(bin), .i_Valid(vin), .o_Ready(r1),
        .o_Diff(d1), .o_Bout(bo1), .o_Valid(v1), .i_Ready(rin), .o_Busy(y1));
    subtractor_nbits_serial #(.WIDTH(15), .CHUNK(15)) u15 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_A(a), .i_B(b), .i_Bin(bin), .i_Valid(vin), .o_Ready(r15),
        .o_Diff(d15), .o_Bout(bo15), .o_Valid(v15), .i_Ready(rin), .o_Busy(y15));

    task automatic accept(input logic [14:0] aa, input logic [14:0] bv, input logic bi);
        @(negedge clk);
        a = aa; b = bv; bin = bi; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic wait_done(output int l4, output int l1, output int l15, output logic hs_bad);
        l4 = 0; l1 = 0; l15 = 0; hs_bad = 1'b0;
        for (int k = 1; k <= 40 && (l4 == 0 || l1 == 0 || l15 == 0); k++) begin
            @(negedge clk);
            if (v4 && l4 == 0) l4 = k;
            if (v1 && l1 == 0) l1 = k;
            if (v15 && l15 == 0) l15 = k;
            if (r4 || !y4) hs_bad = 1'b1;
        end
    endtask

    task automatic release_all();
        @(negedge clk);
        rin = 1'b1;
        @(negedge clk);
        rin = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (r4 !== 1'b1 || v4 !== 1'b0 || y4 !== 1'b0 || d4 !== 15'h0 || bo4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_u4: ready=%b valid=%b busy=%b diff=%h bout=%b, required 1 0 0 0000 0", r4, v4, y4, d4, bo4);
        end
        tests++;
        if (r1 !== 1'b1 || v1 !== 1'b0 || r15 !== 1'b1 || v15 !== 1'b0) begin
            fails++;
            $display("FAIL reset_others: r1=%b v1=%b r15=%b v15=%b, required 1 0 1 0", r1, v1, r15, v15);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int l4, l1, l15;
        logic hs;
        accept(15'h0005, 15'h0003, 1'b0);
        wait_done(l4, l1, l15, hs);
        tests++;
        if ({bo4, d4} !== 16'h0002) begin
            fails++;
            $display("FAIL basic_result: got %b/%h, required 0/0002", bo4, d4);
        end
        tests++;
        if (l4 !== 4) begin
            fails++;
            $display("FAIL basic_latency: got %0d, required 4", l4);
        end
        tests++;
        if (hs !== 1'b0) begin
            fails++;
            $display("FAIL basic_ready_low: o_Ready high or o_Busy low during RUN/DONE");
        end
        release_all();
    endtask

    task automatic test_wrap();
        int l4, l1, l15;
        logic hs;
        accept(15'h0000, 15'h0001, 1'b0);
        wait_done(l4, l1, l15, hs);
        tests++;
        if ({bo4, d4} !== {1'b1, 15'h7FFF}) begin
            fails++;
            $display("FAIL wrap_0_minus_1: got %b/%h, required 1/7fff", bo4, d4);
        end
        release_all();
        accept(15'h7FFF, 15'h7FFF, 1'b1);
        wait_done(l4, l1, l15, hs);
        tests++;
        if ({bo4, d4} !== {1'b1, 15'h7FFF}) begin
            fails++;
            $display("FAIL wrap_max_bin: got %b/%h, required 1/7fff", bo4, d4);
        end
        release_all();
    endtask

    task automatic test_backpressure();
        int l4, l1, l15;
        logic hs;
        accept(15'h0010, 15'h0001, 1'b0);
        wait_done(l4, l1, l15, hs);
        a = 15'h7000; b = 15'h0100; bin = 1'b0; vin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (v4 !== 1'b1 || r4 !== 1'b0 || {bo4, d4} !== 16'h000F) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b result=%b/%h, required 1 0 0/000f", i, v4, r4, bo4, d4);
            end
        end
        vin = 1'b0; rin = 1'b1;
        @(negedge clk);
        rin = 1'b0;
        tests++;
        if (r4 !== 1'b1 || v4 !== 1'b0 || {bo4, d4} !== 16'h000F) begin
            fails++;
            $display("FAIL backpressure_release: ready=%b valid=%b result=%b/%h, required 1 0 0/000f", r4, v4, bo4, d4);
        end
        accept(15'h7000, 15'h0100, 1'b0);
        wait_done(l4, l1, l15, hs);
        tests++;
        if ({bo4, d4} !== 16'h6F00) begin
            fails++;
            $display("FAIL backpressure_next: got %b/%h, required 0/6f00", bo4, d4);
        end
        release_all();
    endtask

    task automatic test_midrun_change();
        int l4, l1, l15;
        logic hs;
        accept(15'h0100, 15'h0001, 1'b0);
        a = 15'h7777; b = 15'h1111; bin = 1'b1;
        wait_done(l4, l1, l15, hs);
        tests++;
        if ({bo4, d4} !== 16'h00FF || {bo1, d1} !== 16'h00FF || {bo15, d15} !== 16'h00FF) begin
            fails++;
            $display("FAIL midrun_change: got %b/%h %b/%h %b/%h, required 0/00ff", bo4, d4, bo1, d1, bo15, d15);
        end
        release_all();
    endtask

    task automatic test_reset_midrun();
        int l4, l1, l15;
        logic hs;
        accept(15'h7FFF, 15'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (r4 !== 1'b1 || v4 !== 1'b0 || y4 !== 1'b0 || y1 !== 1'b0 || y15 !== 1'b0) begin
            fails++;
            $display("FAIL reset_midrun: ready=%b valid=%b busy=%b busy1=%b busy15=%b, required 1 0 0 0 0", r4, v4, y4, y1, y15);
        end
        @(negedge clk);
        rst_n = 1'b1;
        accept(15'h1234, 15'h0234, 1'b0);
        wait_done(l4, l1, l15, hs);
        tests++;
        if ({bo4, d4} !== 16'h1000 || l4 !== 4) begin
            fails++;
            $display("FAIL reset_recover: got %b/%h lat %0d, required 0/1000 lat 4", bo4, d4, l4);
        end
        release_all();
    endtask

    task automatic test_sweep();
        int l4, l1, l15;
        logic hs, vbi;
        logic [14:0] va, vb;
        logic [15:0] g;
        for (int i = 0; i < 25; i++) begin
            va  = i < 5 ? ba[i]  : 15'($urandom);
            vb  = i < 5 ? bb[i]  : 15'($urandom);
            vbi = i < 5 ? bbi[i] : 1'($urandom);
            g   = {1'b0, va} - {1'b0, vb} - 16'(vbi);
            accept(va, vb, vbi);
            wait_done(l4, l1, l15, hs);
            tests++;
            if ({bo4, d4} !== g) begin
                fails++;
                $display("FAIL sweep_c4[%0d] %h-%h-%b: got %b/%h, required %b/%h", i, va, vb, vbi, bo4, d4, g[15], g[14:0]);
            end
            tests++;
            if ({bo1, d1} !== g) begin
                fails++;
                $display("FAIL sweep_c1[%0d] %h-%h-%b: got %b/%h, required %b/%h", i, va, vb, vbi, bo1, d1, g[15], g[14:0]);
            end
            tests++;
            if ({bo15, d15} !== g) begin
                fails++;
                $display("FAIL sweep_c15[%0d] %h-%h-%b: got %b/%h, required %b/%h", i, va, vb, vbi, bo15, d15, g[15], g[14:0]);
            end
            tests++;
            if (l4 !== 4 || l1 !== 15 || l15 !== 1) begin
                fails++;
                $display("FAIL sweep_latency[%0d]: got %0d/%0d/%0d, required 4/15/1", i, l4, l1, l15);
            end
            release_all();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_midrun_change();
        test_reset_midrun();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/subtractor_nbits_serial.md
Name: subtractor_nbits_serial

Overview:
Multi-cycle chunk-serial N-bit subtractor, the inverse arithmetic companion of the N-bit adder. It computes Diff = A - B - Bin with a borrow-out. It processes CHUNK bits per clock, least-significant chunk first, which trades latency for area. Valid/ready handshakes on both sides let it sit in a datapath between a producer and a consumer that can stall.

Parameters:
WIDTH, 15, operand and result width in bits (>=1)
CHUNK, 4, bits processed per cycle (1..WIDTH); NCHUNK = ceil(WIDTH/CHUNK)

Ports:
i_Clk  input  1  clock, rising edge
i_Rst_n  input  1  asynchronous active-low reset
i_A  input  WIDTH  minuend
i_B  input  WIDTH  subtrahend
i_Bin  input  1  borrow-in
i_Valid  input  1  operands valid
o_Ready  output  1  block can accept operands
o_Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH
o_Bout  output  1  borrow-out, 1 when A < B + Bin
o_Valid  output  1  result valid
i_Ready  input  1  consumer accepts result
o_Busy  output  1  operation in progress (state RUN or DONE)

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst_n is asynchronous and active-low.
- On reset assertion, immediately and regardless of state:
  - state=IDLE
  - o_Diff=0, o_Bout=0, o_Valid=0, o_Busy=0
  - o_Ready=1 while reset is low and after it is released
  - internal chunk counter=0, borrow register=0
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - o_Ready=1.
  - An accept happens on a rising edge with i_Valid=1. This edge is E0.
  - At E0, latch i_A, i_B and i_Bin into internal registers, clear the counter, and go to RUN.
  - Operand inputs are ignored at every edge other than an accept.
- RUN:
  - o_Ready=0, o_Busy=1.
  - At each edge E1..E_NCHUNK, process chunk k (bits k*CHUNK upward):
    - diff_k = A_k - B_k - borrow
    - write diff_k into the o_Diff slice
    - update borrow from the chunk-width+1 result MSB
    - increment k
  - Initial borrow = latched Bin.
  - When WIDTH is not a multiple of CHUNK, the last chunk is partial (WIDTH - (NCHUNK-1)*CHUNK bits). The borrow is taken at bit WIDTH, never at a padded position.
  - At edge E_NCHUNK, set o_Bout to the final borrow, set o_Valid=1, and go to DONE.
  - Latency: o_Valid is high NCHUNK cycles after E0 (4 cycles for the defaults).
- DONE:
  - o_Valid=1, o_Ready=0.
  - o_Diff and o_Bout are held stable until handshake.
  - At an edge with i_Ready=1: o_Valid←0, go to IDLE, o_Ready=1 in the following cycle.
  - o_Diff and o_Bout keep their last values after the handshake; only o_Valid qualifies them.
- Throughput: one operation per NCHUNK+2 cycles. No overlap of accept and result handshake.
- i_Valid is ignored outside IDLE.
- i_Ready outside DONE has no effect.
- o_Diff is not valid while o_Valid=0. Partial slices are visible during RUN, and the bench must not check them.
- Degenerate cases:
  - CHUNK=WIDTH: single RUN cycle.
  - CHUNK=1: pure bit-serial, WIDTH RUN cycles.
- Golden model: G = {1'b0,A} - {1'b0,B} - Bin in WIDTH+1 bits. {o_Bout,o_Diff} must equal G at o_Valid.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No result is emitted and the partial result is discarded.

Test Plan:
- A=15'h0005, B=15'h0003, Bin=0 -> o_Valid 4 cycles after accept, o_Diff=15'h0002, o_Bout=0; o_Ready=0 throughout RUN/DONE.
- A=15'h0000, B=15'h0001, Bin=0 -> o_Diff=15'h7FFF, o_Bout=1 (wrap). A=15'h7FFF, B=15'h7FFF, Bin=1 -> o_Diff=15'h7FFF, o_Bout=1.
- Backpressure: hold i_Ready=0 for 5 cycles in DONE while driving i_Valid=1 with new operands -> o_Valid, o_Diff and o_Bout stay stable and the new operands are not accepted. Raise i_Ready -> IDLE next cycle; the next accept then yields the new result.
- Operand change mid-RUN: change i_A/i_B the cycle after accept -> result matches the latched values only.
- Reset pulse during RUN (chunk 2) -> o_Valid=0, o_Busy=0, o_Ready=1 asynchronously. After release, A=15'h1234, B=15'h0234, Bin=0 -> o_Diff=15'h1000, o_Bout=0.
- Sweep 20 random vectors plus boundary vectors (A=B, A=0/B=max, Bin=1 with A=B), each at CHUNK=1, 4 and 15 -> {o_Bout,o_Diff} equals golden G every time; latency equals NCHUNK.
